// File: rtl/encoder_pipe_if.sv
// Handshake bundle for encoder_pipe: one-hot word in, encoded index out.
// Both directions use valid/ready. A beat transfers on a rising edge where valid and ready are both high. Valid must not wait for ready, and the payload must stay stable while valid is high and ready is low.
interface encoder_pipe_if #(
  parameter int M = 4
);
  localparam int N = 2 ** M;

  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [M-1:0] o_encoded;
  logic         o_zero;
  logic         o_multi_hot;
  logic [7:0]   o_err_count;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_encoded, o_zero, o_multi_hot, o_err_count
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_encoded, o_zero, o_multi_hot, o_err_count
  );
endinterface

// File: rtl/encoder_pipe.sv
// Registered lowest-set-bit priority encoder with a 2-entry output buffer.
// Optional ENCODER_PIPE_ONEHOT_CHECK_EN adds per-beat multi-hot flag and a saturating error count.
module encoder_pipe #(
  parameter int M = 4,
  parameter int N = 2 ** M
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  encoder_pipe_if.slave  bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         push, pop;
  logic         load_head_new, load_tail_new, move_tail;
  logic [M-1:0] enc_new, head_enc, tail_enc;
  logic         zero_new, head_zero, tail_zero;

  // Handshake outputs depend only on registered state, never on i_ready.
  assign bus.o_ready = (state_q != ST_FULL);
  assign bus.o_valid = (state_q != ST_EMPTY);
  assign push        = bus.i_valid & bus.o_ready;
  assign pop         = bus.o_valid & bus.i_ready;
  assign dbg_state   = state_q;

  // Walk from the top down so the last hit is the lowest set bit.
  always_comb begin
    enc_new = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.i_data[i]) enc_new = M'(i);
    end
    zero_new = ~|bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_head_new = 1'b0;
    load_tail_new = 1'b0;
    move_tail     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          load_head_new = 1'b1;
          state_d       = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          load_tail_new = 1'b1;
          state_d       = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          move_tail = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_enc  <= '0;
      head_zero <= 1'b0;
      tail_enc  <= '0;
      tail_zero <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_enc  <= enc_new;
        head_zero <= zero_new;
      end else if (move_tail) begin
        head_enc  <= tail_enc;
        head_zero <= tail_zero;
      end
      if (load_tail_new) begin
        tail_enc  <= enc_new;
        tail_zero <= zero_new;
      end
    end
  end

  assign bus.o_encoded = head_enc;
  assign bus.o_zero    = head_zero;

`ifdef ENCODER_PIPE_ONEHOT_CHECK_EN
  logic       mh_new, head_mh, tail_mh;
  logic [7:0] err_q;

  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign mh_new = |(bus.i_data & (bus.i_data - N'(1)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_mh <= 1'b0;
      tail_mh <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      if (load_head_new)  head_mh <= mh_new;
      else if (move_tail) head_mh <= tail_mh;
      if (load_tail_new)  tail_mh <= mh_new;
      if (push && mh_new && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign bus.o_multi_hot = head_mh;
  assign bus.o_err_count = err_q;
`else
  assign bus.o_multi_hot = 1'b0;
  assign bus.o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_encoder_pipe.sv
// Directed bench for encoder_pipe: vector table streamed at full rate plus
// hand-written back-pressure, saturation and mid-transfer reset sequences.
module tb_encoder_pipe;
  localparam int M = 4;
  localparam int N = 2 ** M;
`ifdef ENCODER_PIPE_ONEHOT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;
  int         exp_cnt;

  typedef struct {
    logic [N-1:0] data;
    logic [M-1:0] enc;
    logic         zero;
    logic         mh;
  } vec_t;

  vec_t vecs[$];

  encoder_pipe_if #(.M(M)) bus ();

  encoder_pipe #(.M(M)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bump_model(input logic mh);
    if (CHK_EN && mh && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    chk({tag, "_enc"},   32'(bus.o_encoded), 32'd0);
    chk({tag, "_zero"},  32'(bus.o_zero), 32'd0);
    chk({tag, "_mh"},    32'(bus.o_multi_hot), 32'd0);
    chk({tag, "_cnt"},   32'(bus.o_err_count), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;

    for (int i = 0; i < N; i++) vecs.push_back('{N'(1) << i, M'(i), 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{16'h0030, 4'd4,  1'b0, 1'b1});
    vecs.push_back('{16'h8001, 4'd0,  1'b0, 1'b1});
    vecs.push_back('{16'hFFFF, 4'd0,  1'b0, 1'b1});
    vecs.push_back('{16'h0A00, 4'd9,  1'b0, 1'b1});
    vecs.push_back('{16'h8000, 4'd15, 1'b0, 1'b0});

    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // single beat, 1-cycle latency, then empty again
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0010;
    step();
    chk("t1_valid", 32'(bus.o_valid), 32'd1);
    chk("t1_enc",   32'(bus.o_encoded), 32'd4);
    chk("t1_zero",  32'(bus.o_zero), 32'd0);
    bus.i_valid = 1'b0;
    step();
    chk("t1_empty", 32'(bus.o_valid), 32'd0);

    // table streamed back-to-back with i_ready high
    for (int i = 0; i < vecs.size(); i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = vecs[i].data;
      bump_model(vecs[i].mh);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'd1);
      chk($sformatf("vec%0d_ready", i), 32'(bus.o_ready), 32'd1);
      chk($sformatf("vec%0d_enc", i),   32'(bus.o_encoded), 32'(vecs[i].enc));
      chk($sformatf("vec%0d_zero", i),  32'(bus.o_zero), 32'(vecs[i].zero));
      chk($sformatf("vec%0d_mh", i),    32'(bus.o_multi_hot), 32'(vecs[i].mh & CHK_EN));
      chk($sformatf("vec%0d_cnt", i),   32'(bus.o_err_count), 32'(exp_cnt));
    end
    bus.i_valid = 1'b0;
    step();
    chk("stream_drain", 32'(bus.o_valid), 32'd0);

    // back-pressure: fill both entries, offered word while full must be ignored
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0100;
    step();
    chk("bp1_ready", 32'(bus.o_ready), 32'd1);
    chk("bp1_enc",   32'(bus.o_encoded), 32'd8);
    bus.i_data = 16'h0200;
    step();
    chk("bp2_ready", 32'(bus.o_ready), 32'd0);
    chk("bp2_state", 32'(dbg_state), 32'd2);
    chk("bp2_enc",   32'(bus.o_encoded), 32'd8);
    bus.i_data = 16'h0004;
    step();
    chk("bp3_hold_enc",   32'(bus.o_encoded), 32'd8);
    chk("bp3_hold_ready", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    step();
    chk("bp4_valid", 32'(bus.o_valid), 32'd1);
    chk("bp4_enc",   32'(bus.o_encoded), 32'd9);
    chk("bp4_ready", 32'(bus.o_ready), 32'd1);
    step();
    chk("bp5_empty", 32'(bus.o_valid), 32'd0);

    // saturation of the multi-hot counter
    bus.i_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.i_data = 16'h0003 << (i % 8);
      bump_model(1'b1);
      step();
    end
    bus.i_valid = 1'b0;
    chk("sat_cnt", 32'(bus.o_err_count), 32'(exp_cnt));
    chk("sat_cnt_abs", 32'(bus.o_err_count), CHK_EN ? 32'd255 : 32'd0);
    step();

    // reset while full drops both beats
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0040;
    step();
    bus.i_data  = 16'h0080;
    step();
    chk("full_before_rst", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    step();
    chk("no_stale_1", 32'(bus.o_valid), 32'd0);
    step();
    chk("no_stale_2", 32'(bus.o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
